// File: rtl/legv8_pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline control blocks.
package legv8_pipe_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG_NUM = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/legv8_load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
module legv8_load_use_detect
  import legv8_pipe_pkg::*;
#(
  parameter logic [REG_W-1:0] ZERO_REG = ZERO_REG_NUM
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);
  // XZR reads as zero, so a load targeting it never feeds a consumer.
  assign load_use = ex_memread & (ex_rd != ZERO_REG) &
                    ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
endmodule

// File: rtl/legv8_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage LEGv8 pipeline.
// Define HAZARD_PERF_EN to build the stall_cycles / flush_events counters.
module legv8_hazard_ctrl
  import legv8_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int ZERO_REG     = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
);
  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [1:0]  FLUSH_LOAD  = 2'(FLUSH_CYCLES - 1);

  ctrl_state_t state, state_d;
  logic [15:0] wcnt, wcnt_d;
  logic [1:0]  fcnt, fcnt_d;
  logic        pend, pend_d;
  logic        resume, resume_d;
  logic        tmo_d;
  logic        load_use;

  legv8_load_use_detect #(.ZERO_REG(REG_W'(ZERO_REG))) u_lud (
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rm (id_uses_rm),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    state_d     = state;
    wcnt_d      = wcnt;
    fcnt_d      = fcnt;
    pend_d      = pend;
    resume_d    = resume;
    tmo_d       = mem_timeout;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_d    = MEM_WAIT;
            wcnt_d     = 16'd1;
            resume_d   = 1'b0;
            if (br_taken) pend_d = 1'b1;
          end else if (br_taken | pend) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            pend_d      = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FLUSH_LOAD;
            end
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
          if (br_taken) pend_d = 1'b1;
          if (mem_busy) begin
            if (wcnt == TIMEOUT_VAL) tmo_d = 1'b1;
            else                     wcnt_d = wcnt + 16'd1;
          end else begin
            state_d  = resume ? FLUSH : RUN;
            wcnt_d   = 16'd0;
            resume_d = 1'b0;
          end
        end
        FLUSH: begin
          if (mem_busy) begin
            // Freeze without touching fcnt; the flush picks up where it left off.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_d    = MEM_WAIT;
            wcnt_d     = 16'd1;
            resume_d   = 1'b1;
            if (br_taken) pend_d = 1'b1;
          end else begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (fcnt <= 2'd1) begin
              state_d = RUN;
              fcnt_d  = 2'd0;
            end else begin
              fcnt_d = fcnt - 2'd1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      wcnt        <= 16'd0;
      fcnt        <= 2'd0;
      pend        <= 1'b0;
      resume      <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      wcnt        <= wcnt_d;
      fcnt        <= fcnt_d;
      pend        <= pend_d;
      resume      <= resume_d;
      mem_timeout <= tmo_d;
    end
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_EN
  logic serve_br;
  assign serve_br = !reset && (state == RUN) && !mem_busy && (br_taken | pend);

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_write) stall_cycles <= stall_cycles + 32'd1;
      if (serve_br)  flush_events <= flush_events + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif
endmodule

// File: tb/tb_legv8_hazard_ctrl.sv
// Directed self-checking bench for legv8_hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=255).
module tb_legv8_hazard_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rm, ex_memread, br_taken, mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_flush;
  logic [1:0]  ctrl_state;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, exmem_flush}
  logic [5:0] ctl;
  assign ctl = {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, exmem_flush};

  legv8_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(255), .ZERO_REG(31)) dut (
    .clock(clock), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    id_rn = 5'd1; id_rm = 5'd2; id_uses_rm = 1'b0; ex_memread = 1'b0;
    ex_rd = 5'd9; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    #1;
    checks++; if (ctl !== 6'b001111) begin errors++; $display("FAIL rst_ctl got %b exp %b", ctl, 6'b001111); end
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL post_rst_ctl got %b exp %b", ctl, 6'b111000); end
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL post_rst_state got %0d exp 0", ctrl_state); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL post_rst_tmo got %b exp 0", mem_timeout); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      errors++; $display("FAIL post_rst_perf got %0d/%0d exp 0/0", stall_cycles, flush_events); end
    step();
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
    #1;
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL lu_rn got %b exp %b", ctl, 6'b001100); end
    step(); exp_stall++;
    ex_rd = 5'd31; id_rn = 5'd31;
    #1;
    checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL lu_xzr got %b exp %b", ctl, 6'b111000); end
    step();
    ex_rd = 5'd7; id_rn = 5'd3; id_rm = 5'd7; id_uses_rm = 1'b1;
    #1;
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL lu_rm got %b exp %b", ctl, 6'b001100); end
    step(); exp_stall++;
    id_uses_rm = 1'b0;
    #1;
    checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL lu_rm_unused got %b exp %b", ctl, 6'b111000); end
    step();
    id_uses_rm = 1'b1; ex_memread = 1'b0;
    #1;
    checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL lu_no_load got %b exp %b", ctl, 6'b111000); end
    step();
    idle();
  endtask

  task automatic test_branch();
    br_taken = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111111) begin errors++; $display("FAIL br_first got %b exp %b", ctl, 6'b111111); end
    step(); exp_flush++;
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl !== 6'b111110 || ctrl_state !== 2'd2) begin
        errors++; $display("FAIL br_flush%0d got %b st %0d exp %b st 2", i, ctl, ctrl_state, 6'b111110); end
      step();
    end
    #1;
    checks++; if (ctl !== 6'b111000 || ctrl_state !== 2'd0) begin
      errors++; $display("FAIL br_end got %b st %0d exp %b st 0", ctl, ctrl_state, 6'b111000); end
    step();
  endtask

  task automatic test_mem_busy();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== 6'b000000 || mem_timeout !== 1'b0) begin
        errors++; $display("FAIL mb_freeze%0d got %b tmo %b exp 000000 tmo 0", i, ctl, mem_timeout); end
      if (i > 0) begin
        checks++; if (ctrl_state !== 2'd1) begin errors++; $display("FAIL mb_state%0d got %0d exp 1", i, ctrl_state); end
      end
      step(); exp_stall++;
    end
    mem_busy = 1'b0;
    #1;
    checks++; if (ctl !== 6'b000000 || ctrl_state !== 2'd1) begin
      errors++; $display("FAIL mb_exit got %b st %0d exp 000000 st 1", ctl, ctrl_state); end
    step(); exp_stall++;
    #1;
    checks++; if (ctl !== 6'b111000 || ctrl_state !== 2'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL mb_run got %b st %0d tmo %b exp 111000 st 0 tmo 0", ctl, ctrl_state, mem_timeout); end
    step();
  endtask

  task automatic test_br_load_use();
    br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
    #1;
    checks++; if (ctl !== 6'b111111) begin errors++; $display("FAIL brlu got %b exp %b", ctl, 6'b111111); end
    step(); exp_flush++;
    idle();
    step(); step();
    #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL brlu_end got %0d exp 0", ctrl_state); end
  endtask

  task automatic test_pending();
    mem_busy = 1'b1;
    step(); exp_stall++;
    br_taken = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000 || ctrl_state !== 2'd1) begin
      errors++; $display("FAIL pend_wait got %b st %0d exp 000000 st 1", ctl, ctrl_state); end
    step(); exp_stall++;
    br_taken = 1'b0; mem_busy = 1'b0;
    step(); exp_stall++;
    #1;
    checks++; if (ctl !== 6'b111111 || ctrl_state !== 2'd0) begin
      errors++; $display("FAIL pend_serve got %b st %0d exp 111111 st 0", ctl, ctrl_state); end
    step(); exp_flush++;
    #1;
    checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL pend_flush got %0d exp 2", ctrl_state); end
    step(); step();
    #1;
    checks++; if (ctl !== 6'b111000 || ctrl_state !== 2'd0) begin
      errors++; $display("FAIL pend_end got %b st %0d exp 111000 st 0", ctl, ctrl_state); end
  endtask

  task automatic test_flush_busy();
    br_taken = 1'b1;
    step(); exp_flush++;
    br_taken = 1'b0; mem_busy = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000 || ctrl_state !== 2'd2) begin
      errors++; $display("FAIL fb_freeze got %b st %0d exp 000000 st 2", ctl, ctrl_state); end
    step(); exp_stall++;
    step(); exp_stall++;
    mem_busy = 1'b0;
    step(); exp_stall++;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl !== 6'b111110 || ctrl_state !== 2'd2) begin
        errors++; $display("FAIL fb_resume%0d got %b st %0d exp 111110 st 2", i, ctl, ctrl_state); end
      step();
    end
    #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL fb_end got %0d exp 0", ctrl_state); end
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_EN
    checks++; if (stall_cycles !== 32'(exp_stall)) begin
      errors++; $display("FAIL perf_stall got %0d exp %0d", stall_cycles, exp_stall); end
    checks++; if (flush_events !== 32'(exp_flush)) begin
      errors++; $display("FAIL perf_flush got %0d exp %0d", flush_events, exp_flush); end
`else
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      errors++; $display("FAIL perf_tied got %0d/%0d exp 0/0", stall_cycles, flush_events); end
`endif
  endtask

  task automatic test_timeout();
    mem_busy = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n == 255) begin
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", mem_timeout); end
      end
      if (n == 256 || n == 300) begin
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tmo_set%0d got %b exp 1", n, mem_timeout); end
      end
    end
    mem_busy = 1'b0;
    step(); step();
    #1;
    checks++; if (mem_timeout !== 1'b1 || ctrl_state !== 2'd0) begin
      errors++; $display("FAIL tmo_sticky got %b st %0d exp 1 st 0", mem_timeout, ctrl_state); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (mem_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      errors++; $display("FAIL tmo_clear got %b %0d %0d exp 0 0 0", mem_timeout, stall_cycles, flush_events); end
  endtask

  task automatic test_reset_mid_flush();
    br_taken = 1'b1;
    step();
    br_taken = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (ctrl_state !== 2'd0 || ctl !== 6'b111000) begin
      errors++; $display("FAIL rst_mid_flush got st %0d %b exp st 0 111000", ctrl_state, ctl); end
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_busy();
    test_br_load_use();
    test_pending();
    test_flush_busy();
    test_perf();
    test_timeout();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/legv8_hazard_ctrl.md
Name: legv8_hazard_ctrl

Overview:
- Hazard and pipeline-sequencing controller for the 5-stage LEGv8 pipeline.
- Decides every cycle whether the PC, IF/ID and ID/EX pipeline registers advance, hold, or are loaded with a bubble.
- Detects load-use hazards, flushes wrong-path instructions after a taken branch resolves in MEM, and freezes the pipeline while data memory is busy, with a timeout watchdog.
- Sits beside the pipeline registers; its outputs gate their write enables and zero their control fields.

Parameters:
- FLUSH_CYCLES, 1, cycles the flush is held after a taken branch (1..4).
- MEM_TIMEOUT, 255, maximum consecutive mem_busy cycles before mem_timeout is set (1..65535).
- ZERO_REG, 31, register number that never creates a hazard (XZR).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rn  in  5  Rn field of instruction in ID
- id_rm  in  5  second source register of instruction in ID (after Reg2Loc mux)
- id_uses_rm  in  1  instruction in ID reads id_rm
- ex_memread  in  1  MemRead of instruction in EX (ID/EX stage output)
- ex_rd  in  5  destination register of instruction in EX (Ins4_0 of ID/EX)
- br_taken  in  1  taken branch resolved in MEM stage
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX control fields forced to 0 on this load
- exmem_flush  out  1  EX/MEM control fields forced to 0
- ctrl_state  out  2  current FSM state (0 RUN, 1 MEM_WAIT, 2 FLUSH)
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  32  performance counter (optional feature)
- flush_events  out  32  performance counter (optional feature)

Behaviour:
- All state updates on the rising edge of clock. Reset is synchronous, active-high, and wins over all other inputs.
- Reset values: state RUN, wait counter 0, flush counter 0, mem_timeout 0, both performance counters 0.
- While reset is high, outputs are pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=1, exmem_flush=1, so the pipeline is loaded with bubbles.
- Control outputs are combinational from the current state and current inputs. The controller adds zero latency to hazard response.
- load_use = ex_memread & (ex_rd != ZERO_REG) & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm))).
- Priority within a cycle: mem_busy > br_taken > load_use.
- RUN state:
  - Default outputs: all write enables 1, all flush/bubble outputs 0.
  - mem_busy: pc_write, ifid_write and idex_write all 0; go to MEM_WAIT; wait counter loads 1.
  - Else br_taken: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1 (branch target loads). Go to FLUSH if FLUSH_CYCLES>1, otherwise stay in RUN.
  - Else load_use: pc_write=0, ifid_write=0, idex_bubble=1; stay in RUN. Exactly one bubble results, because the load moves on next cycle.
- MEM_WAIT state:
  - All write enables 0; no flushes.
  - Wait counter increments while mem_busy, saturating at MEM_TIMEOUT.
  - When the counter equals MEM_TIMEOUT with mem_busy still high, mem_timeout is set and stays set until reset. The state is held.
  - When mem_busy drops, go to RUN and clear the counter.
  - A br_taken seen in MEM_WAIT is held in a pending flag and serviced on the first RUN cycle.
- FLUSH state:
  - ifid_flush=1 and idex_bubble=1; write enables 1.
  - The flush counter counts down from FLUSH_CYCLES-1; go to RUN when it reaches 0.
  - mem_busy in FLUSH takes priority: freeze the pipeline as in MEM_WAIT, keep the flush counter, and resume FLUSH afterwards.
- Simultaneous br_taken and load_use: the flush wins and no stall occurs.
- Reset asserted mid-MEM_WAIT or mid-FLUSH returns the block to RUN next edge with all counters cleared.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - stall_cycles increments each cycle pc_write=0 and reset is low.
  - flush_events increments on each cycle RUN services br_taken (including a pending branch).
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by reset.
- When undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package legv8_pipe_pkg holds:
  - state encoding constants RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2;
  - ZERO_REG_NUM=5'd31;
  - register-number width REG_W=5.
- One sub-module, legv8_load_use_detect: purely combinational compare producing load_use. Everything else stays in the top.

Test Plan:
- Reset held for 2 cycles, then released with idle inputs: during reset pc_write=0 and all flush outputs=1; first cycle after release is RUN with pc_write=1 and flushes=0.
- ex_memread=1, ex_rd=5, id_rn=5 for one cycle: pc_write=0, ifid_write=0, idex_bubble=1 that cycle. With ex_rd=31 instead, no stall.
- br_taken=1 for one cycle with FLUSH_CYCLES=3: ifid_flush=1 for exactly 3 consecutive cycles, then RUN. With HAZARD_PERF_EN defined, flush_events=1.
- mem_busy high for 4 cycles with MEM_TIMEOUT=255: all write enables 0 for 4 cycles, ctrl_state=1, mem_timeout stays 0, then RUN.
- mem_busy held for 300 cycles with MEM_TIMEOUT=255: mem_timeout=1 after 255 cycles and stays set after mem_busy drops, until reset.
- br_taken and load_use asserted in the same cycle, and br_taken during MEM_WAIT: flush takes priority with no stall; the pending branch flushes on the first RUN cycle after mem_busy drops.
